// File: rtl/rr_mux_arbiter_if.sv
// Handshake bundle between the input channels, the arbiter and the output consumer.
// The slave modport is the arbiter's view; the master modport drives it.
interface rr_mux_arbiter_if #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4
);
    localparam int SELW = $clog2(CHANNELS);

    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic                      mode;
    logic [SELW-1:0]           sel;
    logic [WIDTH-1:0]          out_data;
    logic [SELW-1:0]           out_chan;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Multi-channel mux with manual or round-robin selection feeding a single
// registered output stage that sustains one word per cycle.
module rr_mux_arbiter #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4
) (
    input  logic             clk,
    input  logic             reset,
    rr_mux_arbiter_if.slave  bus
);
    localparam int SELW = $clog2(CHANNELS);

    logic [WIDTH-1:0]    r_outData;
    logic [SELW-1:0]     r_outChan;
    logic                r_outValid;
    logic [SELW-1:0]     r_ptr;

    logic                w_loadEn;
    logic                w_rrFound;
    logic [SELW-1:0]     w_rrIdx;
    logic [SELW-1:0]     w_probe;
    logic                w_grantValid;
    logic [SELW-1:0]     w_grantIdx;
    logic                w_xfer;
    logic [WIDTH-1:0]    w_grantData;
    logic [CHANNELS-1:0] w_inReady;

    // Search starts just past the last granted channel, so ptr itself is tried last.
    always_comb begin
        w_rrFound = 1'b0;
        w_rrIdx   = '0;
        w_probe   = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            w_probe = r_ptr + SELW'(k);
            if (!w_rrFound && bus.in_valid[w_probe]) begin
                w_rrFound = 1'b1;
                w_rrIdx   = w_probe;
            end
        end
    end

    assign w_loadEn     = ~r_outValid | bus.out_ready;
    assign w_grantValid = bus.mode ? w_rrFound : bus.in_valid[bus.sel];
    assign w_grantIdx   = bus.mode ? w_rrIdx : bus.sel;
    assign w_xfer       = ~reset & w_loadEn & w_grantValid;
    assign w_grantData  = bus.in_data[w_grantIdx*WIDTH +: WIDTH];

    always_comb begin
        w_inReady = '0;
        if (w_xfer) begin
            w_inReady[w_grantIdx] = 1'b1;
        end
    end

    // A refill takes priority over a drain, which gives back-to-back throughput.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_outData  <= '0;
            r_outChan  <= '0;
            r_outValid <= 1'b0;
            r_ptr      <= SELW'(CHANNELS - 1);
        end else if (w_xfer) begin
            r_outData  <= w_grantData;
            r_outChan  <= w_grantIdx;
            r_outValid <= 1'b1;
            r_ptr      <= w_grantIdx;
        end else if (r_outValid && bus.out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_inReady;
    assign bus.out_data  = r_outData;
    assign bus.out_chan  = r_outChan;
    assign bus.out_valid = r_outValid;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench: each granted word is queued when driven and checked one edge later.
module tb_rr_mux_arbiter;
    localparam int WIDTH    = 4;
    localparam int CHANNELS = 4;

    typedef struct packed {
        logic [1:0] chan;
        logic [3:0] data;
    } item_t;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    item_t      sbq[$];
    logic [3:0] chData [CHANNELS];
    logic       drivenReady;
    logic       mValid;
    logic [3:0] mData;
    logic [1:0] mChan;

    rr_mux_arbiter_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

    rr_mux_arbiter #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one cycle of inputs and checks the combinational grant before the edge.
    task automatic applyStimulus(input logic rst, input logic [3:0] v, input logic m,
                                 input logic [1:0] s, input logic r, input logic [3:0] expReady);
        item_t it;
        reset        = rst;
        bus.in_valid = v;
        bus.mode     = m;
        bus.sel      = s;
        bus.out_ready = r;
        drivenReady  = r;
        for (int i = 0; i < CHANNELS; i++) bus.in_data[i*WIDTH +: WIDTH] = chData[i];
        #1;
        check("in_ready", 32'(bus.in_ready), 32'(expReady));
        for (int i = 0; i < CHANNELS; i++) begin
            if (expReady[i]) begin
                it.chan = 2'(i);
                it.data = chData[i];
                sbq.push_back(it);
            end
        end
    endtask

    task automatic checkOutput();
        item_t it;
        @(posedge clk);
        #1;
        if (reset) begin
            sbq.delete();
            mValid = 1'b0;
            mData  = '0;
            mChan  = '0;
        end else if (sbq.size() > 0) begin
            it     = sbq.pop_front();
            mValid = 1'b1;
            mData  = it.data;
            mChan  = it.chan;
        end else if (drivenReady) begin
            mValid = 1'b0;
        end
        check("out_valid", 32'(bus.out_valid), 32'(mValid));
        check("out_data", 32'(bus.out_data), 32'(mData));
        check("out_chan", 32'(bus.out_chan), 32'(mChan));
        @(negedge clk);
    endtask

    task automatic step(input logic rst, input logic [3:0] v, input logic m,
                        input logic [1:0] s, input logic r, input logic [3:0] expReady);
        applyStimulus(rst, v, m, s, r, expReady);
        checkOutput();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        mValid = 1'b0;
        mData  = '0;
        mChan  = '0;
        for (int i = 0; i < CHANNELS; i++) chData[i] = 4'(i + 1);
        reset = 1'b1;
        bus.in_valid = '0;
        bus.in_data = '0;
        bus.mode = 1'b1;
        bus.sel = '0;
        bus.out_ready = 1'b1;
        drivenReady = 1'b1;
        @(negedge clk);

        // Reset with every channel offering and the consumer ready.
        step(1'b1, 4'b1111, 1'b1, 2'd0, 1'b1, 4'b0000);
        step(1'b1, 4'b1111, 1'b1, 2'd0, 1'b1, 4'b0000);

        // Round-robin sweep 0,1,2,3,0 then on to ch3.
        step(1'b0, 4'b1111, 1'b1, 2'd0, 1'b1, 4'b0001);
        step(1'b0, 4'b1111, 1'b1, 2'd0, 1'b1, 4'b0010);
        step(1'b0, 4'b1111, 1'b1, 2'd0, 1'b1, 4'b0100);
        step(1'b0, 4'b1111, 1'b1, 2'd0, 1'b1, 4'b1000);
        step(1'b0, 4'b1111, 1'b1, 2'd0, 1'b1, 4'b0001);
        step(1'b0, 4'b1111, 1'b1, 2'd0, 1'b1, 4'b0010);
        step(1'b0, 4'b1111, 1'b1, 2'd0, 1'b1, 4'b0100);
        step(1'b0, 4'b1111, 1'b1, 2'd0, 1'b1, 4'b1000);

        // Skip and wrap after ch3.
        step(1'b0, 4'b0010, 1'b1, 2'd0, 1'b1, 4'b0010);
        step(1'b0, 4'b0011, 1'b1, 2'd0, 1'b1, 4'b0001);

        // Backpressure: held word stays put even as mode/sel change.
        step(1'b0, 4'b0100, 1'b1, 2'd0, 1'b0, 4'b0000);
        step(1'b0, 4'b0100, 1'b0, 2'd2, 1'b0, 4'b0000);
        step(1'b0, 4'b1111, 1'b1, 2'd3, 1'b0, 4'b0000);
        step(1'b0, 4'b0100, 1'b1, 2'd0, 1'b1, 4'b0100);

        // Drain with nothing offered.
        step(1'b0, 4'b0000, 1'b1, 2'd0, 1'b1, 4'b0000);
        step(1'b0, 4'b0000, 1'b1, 2'd0, 1'b1, 4'b0000);

        // Manual select: valid channel granted, invalid selection grants none.
        chData[2] = 4'hA;
        step(1'b0, 4'b0100, 1'b0, 2'd2, 1'b1, 4'b0100);
        step(1'b0, 4'b0100, 1'b0, 2'd3, 1'b1, 4'b0000);
        step(1'b0, 4'b0100, 1'b0, 2'd3, 1'b1, 4'b0000);

        // Mid-operation reset with a held ch2 word and ptr at 2.
        chData[2] = 4'd3;
        step(1'b0, 4'b0100, 1'b0, 2'd2, 1'b1, 4'b0100);
        step(1'b0, 4'b1111, 1'b1, 2'd0, 1'b0, 4'b0000);
        step(1'b1, 4'b1111, 1'b1, 2'd0, 1'b0, 4'b0000);
        step(1'b0, 4'b1111, 1'b1, 2'd0, 1'b1, 4'b0001);
        step(1'b0, 4'b1111, 1'b1, 2'd0, 1'b1, 4'b0010);

        check("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
